lsu_sq_retire_ctrl: RTL
=======================

Name: lsu_sq_retire_ctrl

Overview:
Sequences retirement of committed stores from the store queue into the data cache or the miss-status queue (MSQ).
- Shares the single D$ port between the load pipeline and retiring stores.
- Stores get forced priority once they have waited too long.
- Handshakes with the ROB (stall/ack) and tells the SQ when to free the retired slot.

Parameters:
STARVE_LIMIT, 4, consecutive denied ARB cycles after which the store overrides load priority (must be >= 1)

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
i_rob_retire_en  in  1  ROB requests retirement of store with i_rob_retire_tag; held stable until o_rob_retire_ack
i_rob_retire_tag  in  procyon_tag_t  ROB tag of retiring store
o_rob_retire_stall  out  1  ROB must not advance retirement
o_rob_retire_ack  out  1  one-cycle pulse: store fully written to D$ or MSQ
o_sq_lookup_tag  out  procyon_tag_t  tag driven to SQ for combinational slot read (= i_rob_retire_tag)
i_sq_data  in  procyon_data_t  store data of looked-up slot
i_sq_addr  in  procyon_addr_t  store address
i_sq_lsu_func  in  procyon_lsu_func_t  SB/SH/SW
o_sq_dealloc_en  out  1  one-cycle pulse: clear SQ slot o_sq_lookup_tag
i_ld_req  in  1  load pipeline requests D$ port this cycle
o_ld_gnt  out  1  load owns D$ port this cycle
o_dc_en  out  1  store access to D$ (lookup or write)
o_dc_we  out  1  write qualifier for o_dc_en
o_dc_addr  out  procyon_addr_t  store address
o_dc_data  out  procyon_data_t  store data
o_dc_lsu_func  out  procyon_lsu_func_t  store type
i_dc_hit  in  1  lookup result, valid the cycle after a lookup (o_dc_en & ~o_dc_we)
o_msq_en  out  1  allocate/merge store in MSQ
o_msq_addr, o_msq_data, o_msq_lsu_func  out  as D$  MSQ payload (= latched store)
i_msq_full  in  1  MSQ cannot accept

Behaviour:
Reset:
- State IDLE; starvation counter 0.
- Latched store registers are not reset.
- All outputs 0, except o_ld_gnt = i_ld_req and o_rob_retire_stall = i_rob_retire_en.

FSM (one transition per clk):
- IDLE:
  - if i_rob_retire_en, latch i_sq_data/addr/lsu_func, clear counter, -> ARB.
  - o_ld_gnt = i_ld_req.
- ARB:
  - Store wins if ~i_ld_req or counter == STARVE_LIMIT.
  - Win: o_dc_en=1, o_dc_we=0, o_ld_gnt=0, -> RESP.
  - Lose: o_ld_gnt=1, counter++ (saturating at STARVE_LIMIT), stay.
  - Counter width $clog2(STARVE_LIMIT+1).
- RESP:
  - o_ld_gnt = i_ld_req.
  - i_dc_hit -> WRITE; else -> MSQ.
- WRITE:
  - o_dc_en=1, o_dc_we=1, o_ld_gnt=0 (store always wins, one cycle).
  - -> DONE.
- MSQ:
  - o_ld_gnt = i_ld_req.
  - if ~i_msq_full: o_msq_en=1, -> DONE; else stay (retry every cycle).
- DONE:
  - o_rob_retire_ack=1, o_sq_dealloc_en=1, o_ld_gnt = i_ld_req.
  - -> IDLE.

Outputs and datapath:
- o_dc_*/o_msq_* payload always driven from latched registers. Payload is don't-care when its enable is low; the bench checks it only when enabled.
- o_rob_retire_stall = (state != IDLE && state != DONE) || (state == IDLE && i_rob_retire_en).
- o_sq_lookup_tag = i_rob_retire_tag (combinational).

Latency:
- Uncontended hit: retire_en at cycle 0; lookup c1; RESP c2; write c3; ack c4.
- Miss with MSQ free: ack c4, o_msq_en at c3.

Boundary and simultaneous cases:
- Back-to-back stores: retire_en may stay high in the DONE cycle; the next store is captured in the following IDLE cycle (minimum 5-cycle spacing).
- No flush port: a retiring store is architecturally committed and always completes.
- i_ld_req and i_msq_full may toggle arbitrarily; only the rules above apply.
- Asynchronous reset mid-operation returns to IDLE immediately:
  - no ack or dealloc is generated;
  - the ROB/SQ are reset by the same n_rst.
- Invariant: o_ld_gnt & o_dc_en never both high.

Test Plan:
1. Uncontended hit: retire tag 5, addr 0x100, data 0xDEADBEEF, SW, i_dc_hit=1 -> lookup at c1; write c3 with addr 0x100/data 0xDEADBEEF; ack + dealloc at c4; stall high c0–c3.
2. Miss with MSQ full: i_dc_hit=0, i_msq_full=1 for 3 cycles then 0 -> state holds in MSQ; o_msq_en single pulse on the first non-full cycle; ack the following cycle.
3. Load contention/starvation, STARVE_LIMIT=4: i_ld_req held high -> o_ld_gnt high for 4 ARB cycles; store lookup on the 5th; o_ld_gnt low that cycle and during WRITE.
4. Back-to-back stores: tags 1 then 2, retire_en continuously high -> two acks exactly 5 cycles apart; each dealloc carries the matching tag; second payload equals second SQ entry.
5. Reset mid-operation: n_rst asserted while in WRITE -> outputs at reset values asynchronously; no ack; after release with retire_en low, state stays IDLE.
6. Random ld_req/hit/msq_full for 10k cycles -> never o_ld_gnt&o_dc_en; exactly one ack per accepted retire; ack count == dealloc count.

Source files
------------

// File: rtl/lsu_sq_retire_ctrl.sv
// lsu_sq_retire_ctrl
// Retires committed stores from the store queue into the data cache or, on a
// cache miss, into the miss-status queue. The single D$ port is shared with
// the load pipeline; a store that keeps losing arbitration eventually takes
// the port by force.
//
// Ports
//   clk, n_rst                 clock, asynchronous active-low reset
//   i_rob_retire_en/_tag       ROB retirement request (held until ack)
//   o_rob_retire_stall/_ack    ROB handshake
//   o_sq_lookup_tag            SQ slot read address (= retiring tag)
//   i_sq_data/_addr/_lsu_func  SQ slot contents
//   o_sq_dealloc_en            free the retired SQ slot
//   i_ld_req / o_ld_gnt        load pipeline D$ port arbitration
//   o_dc_*                     store lookup / write to D$
//   i_dc_hit                   lookup result, the cycle after the lookup
//   o_msq_* / i_msq_full       MSQ allocation on a miss
module lsu_sq_retire_ctrl #(
  parameter int STARVE_LIMIT = 4,
  parameter int TAG_W        = 6,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int FUNC_W       = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_rob_retire_en,
  input  logic [TAG_W-1:0]  i_rob_retire_tag,
  output logic              o_rob_retire_stall,
  output logic              o_rob_retire_ack,
  output logic [TAG_W-1:0]  o_sq_lookup_tag,
  input  logic [DATA_W-1:0] i_sq_data,
  input  logic [ADDR_W-1:0] i_sq_addr,
  input  logic [FUNC_W-1:0] i_sq_lsu_func,
  output logic              o_sq_dealloc_en,
  input  logic              i_ld_req,
  output logic              o_ld_gnt,
  output logic              o_dc_en,
  output logic              o_dc_we,
  output logic [ADDR_W-1:0] o_dc_addr,
  output logic [DATA_W-1:0] o_dc_data,
  output logic [FUNC_W-1:0] o_dc_lsu_func,
  input  logic              i_dc_hit,
  output logic              o_msq_en,
  output logic [ADDR_W-1:0] o_msq_addr,
  output logic [DATA_W-1:0] o_msq_data,
  output logic [FUNC_W-1:0] o_msq_lsu_func,
  input  logic              i_msq_full
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_RESP,
    ST_WRITE,
    ST_MSQ,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [FUNC_W-1:0] func_q;
  logic              capture;

  assign capture = (state_q == ST_IDLE) && i_rob_retire_en;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Store payload is only meaningful while a store is in flight, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      data_q <= i_sq_data;
      addr_q <= i_sq_addr;
      func_q <= i_sq_lsu_func;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    o_ld_gnt         = i_ld_req;
    o_dc_en          = 1'b0;
    o_dc_we          = 1'b0;
    o_msq_en         = 1'b0;
    o_rob_retire_ack = 1'b0;
    o_sq_dealloc_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_rob_retire_en) begin
          cnt_d   = '0;
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        // The store wins when the load is idle or it has been denied
        // STARVE_LIMIT cycles in a row.
        if (!i_ld_req || (cnt_q == CNT_MAX)) begin
          o_dc_en  = 1'b1;
          o_ld_gnt = 1'b0;
          state_d  = ST_RESP;
        end else begin
          o_ld_gnt = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = i_dc_hit ? ST_WRITE : ST_MSQ;
      end
      ST_WRITE: begin
        // The line was just confirmed present; the write takes the port
        // unconditionally for one cycle.
        o_dc_en  = 1'b1;
        o_dc_we  = 1'b1;
        o_ld_gnt = 1'b0;
        state_d  = ST_DONE;
      end
      ST_MSQ: begin
        if (!i_msq_full) begin
          o_msq_en = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        o_rob_retire_ack = 1'b1;
        o_sq_dealloc_en  = 1'b1;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_rob_retire_stall = ((state_q != ST_IDLE) && (state_q != ST_DONE)) ||
                              capture;
  assign o_sq_lookup_tag    = i_rob_retire_tag;

  assign o_dc_addr      = addr_q;
  assign o_dc_data      = data_q;
  assign o_dc_lsu_func  = func_q;
  assign o_msq_addr     = addr_q;
  assign o_msq_data     = data_q;
  assign o_msq_lsu_func = func_q;

endmodule
